// File: rtl/mat_fifo_wr_arb_pkg.sv
// Shared helpers for the FIFO write-side arbiter.
package mat_fifo_wr_arb_pkg;

  // Modular add for operands already below n. A compare and subtract is
  // enough here, so no divider is built.
  function automatic int unsigned wrap_add(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned n);
    int unsigned s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/mat_fifo_rr_pick.sv
// Cyclic priority search: returns the first set request bit at or after ptr.
module mat_fifo_rr_pick
  import mat_fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       valid
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] cand;

  // Walk offsets 0..NUM_REQ-1 from ptr; the lowest offset with a request wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'(wrap_add(32'(ptr), 32'(k), 32'(NUM_REQ)));
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mat_fifo_wr_arb.sv
// Round-robin burst arbiter feeding one shared FIFO write port.
// A requester owns the port from grant until its last beat or until the
// per-grant beat limit; one IDLE cycle always separates two bursts.
module mat_fifo_wr_arb
  import mat_fifo_wr_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_a;
  logic [IW-1:0]                      pick_idx;
  logic                               pick_valid;
  logic                               burst_end;

  assign req_data_a = req_data;

  mat_fifo_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Write path: owner's ready follows ~full with no register in between.
  // rst masks it so a burst being aborted cannot slip one more beat out.
  always_comb begin
    req_ready = '0;
    if (state_q == ST_BURST && !rst) req_ready[grant_q] = ~fifo_full;
    fifo_wr_en   = req_valid[grant_q] & req_ready[grant_q];
    fifo_wr_data = req_data_a[grant_q];
  end

  assign grant_id  = grant_q;
  assign busy      = (state_q == ST_BURST);
  assign burst_end = req_last[grant_q] || (beat_cnt_q == CNT_LAST);

  // Next state: grant in IDLE, count accepted beats in BURST, release the
  // port on last beat or beat limit and advance the round-robin pointer.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d    = ST_BURST;
          grant_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      ST_BURST: begin
        if (fifo_wr_en) begin
          if (burst_end) begin
            state_d    = ST_IDLE;
            rr_ptr_d   = IW'(wrap_add(32'(grant_q), 32'd1, 32'(NUM_REQ)));
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and grant registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_mat_fifo_wr_arb.sv
// Directed bench for mat_fifo_wr_arb: vector table plus a beat-limit sequence.
module tb_mat_fifo_wr_arb;

  localparam int DW = 32;
  localparam int NR = 4;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_wr_data;
  logic [1:0]       grant_id;
  logic             busy;

  int checks;
  int passed;

  mat_fifo_wr_arb #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .MAX_BURST  (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic        full;
    logic [31:0] d;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  rdy;
    logic        busy;
    logic [1:0]  gnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l,
                     input logic f, input logic [31:0] d, input logic we,
                     input logic [31:0] wd, input logic [3:0] rd,
                     input logic b, input logic [1:0] g);
    vec_t t;
    t.rst = r; t.vld = v; t.lst = l; t.full = f; t.d = d;
    t.wen = we; t.wdata = wd; t.rdy = rd; t.busy = b; t.gnt = g;
    vq.push_back(t);
  endtask

  // Requester i presents d + i<<28 so a wrong slice shows in the top nibble.
  task automatic apply(input vec_t t);
    rst       = t.rst;
    req_valid = t.vld;
    req_last  = t.lst;
    fifo_full = t.full;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = t.d + (32'(i) << 28);
  endtask

  logic [39:0] act, exp;
  logic [31:0] got_d[$];
  logic [1:0]  got_g[$];
  logic [31:0] exp_d[$];
  logic [1:0]  exp_g[$];
  int p0, q1;

  initial begin
    checks = 0; passed = 0;
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;

    //   rst vld    lst    full d          wen wdata         rdy    busy gnt
    // reset state
    add(1, 4'b0000, 4'b0000, 0, 32'h00, 0, 32'h0,        4'b0000, 0, 2'd0);
    // requester 2: A,B,C with last on C
    add(0, 4'b0100, 4'b0000, 0, 32'h0A, 0, 32'h0,        4'b0000, 0, 2'd0);
    add(0, 4'b0100, 4'b0000, 0, 32'h0A, 1, 32'h2000000A, 4'b0100, 1, 2'd2);
    add(0, 4'b0100, 4'b0000, 0, 32'h0B, 1, 32'h2000000B, 4'b0100, 1, 2'd2);
    add(0, 4'b0100, 4'b0100, 0, 32'h0C, 1, 32'h2000000C, 4'b0100, 1, 2'd2);
    add(0, 4'b0000, 4'b0000, 0, 32'h00, 0, 32'h0,        4'b0000, 0, 2'd2);
    // all valid, 1-beat bursts: rotation 3,0,1,2,3 from rr_ptr=3
    add(0, 4'b1111, 4'b1111, 0, 32'h10, 0, 32'h0,        4'b0000, 0, 2'd2);
    add(0, 4'b1111, 4'b1111, 0, 32'h11, 1, 32'h30000011, 4'b1000, 1, 2'd3);
    add(0, 4'b1111, 4'b1111, 0, 32'h00, 0, 32'h0,        4'b0000, 0, 2'd3);
    add(0, 4'b1111, 4'b1111, 0, 32'h12, 1, 32'h00000012, 4'b0001, 1, 2'd0);
    add(0, 4'b1111, 4'b1111, 0, 32'h00, 0, 32'h0,        4'b0000, 0, 2'd0);
    add(0, 4'b1111, 4'b1111, 0, 32'h13, 1, 32'h10000013, 4'b0010, 1, 2'd1);
    add(0, 4'b1111, 4'b1111, 0, 32'h00, 0, 32'h0,        4'b0000, 0, 2'd1);
    add(0, 4'b1111, 4'b1111, 0, 32'h14, 1, 32'h20000014, 4'b0100, 1, 2'd2);
    add(0, 4'b1111, 4'b1111, 0, 32'h00, 0, 32'h0,        4'b0000, 0, 2'd2);
    add(0, 4'b1111, 4'b1111, 0, 32'h15, 1, 32'h30000015, 4'b1000, 1, 2'd3);
    add(0, 4'b0000, 4'b0000, 0, 32'h00, 0, 32'h0,        4'b0000, 0, 2'd3);
    // requester 1 with fifo_full for 5 cycles mid-burst
    add(0, 4'b0010, 4'b0000, 0, 32'h00, 0, 32'h0,        4'b0000, 0, 2'd3);
    add(0, 4'b0010, 4'b0000, 0, 32'h21, 1, 32'h10000021, 4'b0010, 1, 2'd1);
    for (int i = 0; i < 5; i++)
      add(0, 4'b0010, 4'b0000, 1, 32'h22, 0, 32'h0,      4'b0000, 1, 2'd1);
    add(0, 4'b0010, 4'b0000, 0, 32'h22, 1, 32'h10000022, 4'b0010, 1, 2'd1);
    add(0, 4'b0010, 4'b0010, 0, 32'h23, 1, 32'h10000023, 4'b0010, 1, 2'd1);
    add(0, 4'b0000, 4'b0000, 0, 32'h00, 0, 32'h0,        4'b0000, 0, 2'd1);
    // requester 2 (rr_ptr=2), reset on beat 2, next grant from requester 0
    add(0, 4'b0100, 4'b0000, 0, 32'h00, 0, 32'h0,        4'b0000, 0, 2'd1);
    add(0, 4'b0100, 4'b0000, 0, 32'h41, 1, 32'h20000041, 4'b0100, 1, 2'd2);
    add(1, 4'b0100, 4'b0000, 0, 32'h42, 0, 32'h0,        4'b0000, 1, 2'd2);
    add(0, 4'b0101, 4'b0000, 0, 32'h43, 0, 32'h0,        4'b0000, 0, 2'd0);
    add(0, 4'b0101, 4'b0001, 0, 32'h50, 1, 32'h00000050, 4'b0001, 1, 2'd0);
    add(0, 4'b0000, 4'b0000, 0, 32'h00, 0, 32'h0,        4'b0000, 0, 2'd0);
    // requester 3 drops valid 3 cycles while requester 0 waits
    add(0, 4'b1000, 4'b0000, 0, 32'h00, 0, 32'h0,        4'b0000, 0, 2'd0);
    add(0, 4'b1000, 4'b0000, 0, 32'h31, 1, 32'h30000031, 4'b1000, 1, 2'd3);
    for (int i = 0; i < 3; i++)
      add(0, 4'b0001, 4'b0000, 0, 32'h77, 0, 32'h0,      4'b1000, 1, 2'd3);
    add(0, 4'b1000, 4'b1000, 0, 32'h32, 1, 32'h30000032, 4'b1000, 1, 2'd3);
    add(0, 4'b0000, 4'b0000, 0, 32'h00, 0, 32'h0,        4'b0000, 0, 2'd3);

    repeat (2) @(negedge clk);

    foreach (vq[n]) begin
      @(negedge clk);
      apply(vq[n]);
      #1;
      act = {fifo_wr_en, (vq[n].wen ? fifo_wr_data : 32'h0), req_ready, busy, grant_id};
      exp = {vq[n].wen, (vq[n].wen ? vq[n].wdata : 32'h0), vq[n].rdy, vq[n].busy, vq[n].gnt};
      checks++;
      if (act === exp) passed++;
      else $display("FAIL vec%0d: got wen=%b data=%h rdy=%b busy=%b gnt=%0d, expected wen=%b data=%h rdy=%b busy=%b gnt=%0d",
                    n, act[39], act[38:7], act[6:3], act[2], act[1:0],
                    exp[39], exp[38:7], exp[6:3], exp[2], exp[1:0]);
    end

    // Beat limit: 20-beat packet from requester 0, 2-beat packet from 1 pending.
    p0 = 0; q1 = 0;
    for (int c = 0; c < 100 && !(p0 == 20 && q1 == 2); c++) begin
      @(negedge clk);
      rst = 1'b0; fifo_full = 1'b0;
      req_valid = {2'b00, q1 < 2, p0 < 20};
      req_last  = {2'b00, q1 == 1, p0 == 19};
      req_data  = '0;
      req_data[31:0]  = 32'h100 + p0;
      req_data[63:32] = 32'h1000_0200 + q1;
      #1;
      if (fifo_wr_en) begin got_d.push_back(fifo_wr_data); got_g.push_back(grant_id); end
      if (req_valid[0] && req_ready[0]) p0++;
      if (req_valid[1] && req_ready[1]) q1++;
    end
    checks++;
    if (p0 == 20 && q1 == 2) passed++;
    else $display("FAIL burst_timeout: got p0=%0d q1=%0d, expected 20 and 2", p0, q1);

    for (int k = 0; k < 16; k++) begin exp_d.push_back(32'h100 + k); exp_g.push_back(2'd0); end
    for (int k = 0; k < 2; k++)  begin exp_d.push_back(32'h1000_0200 + k); exp_g.push_back(2'd1); end
    for (int k = 16; k < 20; k++) begin exp_d.push_back(32'h100 + k); exp_g.push_back(2'd0); end

    checks++;
    if (got_d.size() == exp_d.size()) passed++;
    else $display("FAIL burst_count: got %0d writes, expected %0d", got_d.size(), exp_d.size());
    for (int k = 0; k < exp_d.size() && k < got_d.size(); k++) begin
      checks++;
      if (got_d[k] === exp_d[k] && got_g[k] === exp_g[k]) passed++;
      else $display("FAIL burst_beat%0d: got gnt=%0d data=%h, expected gnt=%0d data=%h",
                    k, got_g[k], got_d[k], exp_g[k], exp_d[k]);
    end

    // Port returns to IDLE after the final last beat.
    @(negedge clk);
    req_valid = '0; req_last = '0;
    #1;
    checks++;
    if (busy === 1'b0 && fifo_wr_en === 1'b0 && req_ready === 4'b0000) passed++;
    else $display("FAIL final_idle: got busy=%b wen=%b rdy=%b, expected 0 0 0000",
                  busy, fifo_wr_en, req_ready);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
